// File: rtl/mem_req_scheduler.sv
// Line-request scheduler between the bus arbiter and the single main-memory port.
// Posted writes coalesce in a small FIFO-ordered buffer; reads forward from it on a hit or go to memory.
// Latency: forwarded read 1 cycle after accept; memory read returns up_rvalid in the mem_rvalid cycle.
module mem_req_scheduler #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int DEPTH   = 4,
  parameter int HIGH_WM = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_req,
  input  logic                       up_write,
  input  logic [ADDR_W-1:0]          up_addr,
  input  logic [LINE_W-1:0]          up_wdata,
  output logic                       up_ready,
  output logic                       up_rvalid,
  output logic [LINE_W-1:0]          up_rdata,
  input  logic                       flush,
  output logic                       idle,
  output logic [$clog2(DEPTH):0]     wb_count,
  output logic                       mem_req,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [LINE_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic                       mem_rvalid,
  input  logic [LINE_W-1:0]          mem_rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_FWD,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  wb_addr [DEPTH];
  logic [LINE_W-1:0]  wb_data [DEPTH];
  logic [DEPTH-1:0]   wb_vld;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;

  logic [ADDR_W-1:0]  rd_addr;    // address of the read miss sent to memory
  logic               rd_pend;    // miss accepted while a write owns the memory port
  logic               fwd_vld;    // forwarded read data strobe
  logic [LINE_W-1:0]  fwd_dat;

  logic               full, drain_now, in_rd, locked;
  logic               acc, wr_acc, rd_acc, rd_hit_acc, rd_miss_acc;
  logic               any_hit, unl_hit;
  logic [PTR_W-1:0]   unl_idx, fwd_idx;
  logic               push, pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign in_rd     = (state == RD_FWD) || (state == RD_ISSUE) || (state == RD_WAIT);
  assign locked    = (state == WR_ISSUE);
  // Drain ahead of new traffic: writes take the port and requests stall for this cycle.
  assign drain_now = (state == IDLE) && (count != '0) && (flush || (count >= CNT_W'(HIGH_WM)));

  assign up_ready  = !full && !in_rd && !rd_pend && !drain_now;
  assign acc       = up_req && up_ready;
  assign wr_acc    = acc && up_write;
  assign rd_acc    = acc && !up_write;
  assign rd_hit_acc  = rd_acc && any_hit;
  assign rd_miss_acc = rd_acc && !any_hit;

  // Address match against the buffer; the head being issued is locked and never coalesced into.
  always_comb begin
    any_hit = 1'b0;
    unl_hit = 1'b0;
    unl_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_vld[i] && (wb_addr[i] == up_addr)) begin
        any_hit = 1'b1;
        if (!(locked && (PTR_W'(i) == head))) begin
          unl_hit = 1'b1;
          unl_idx = PTR_W'(i);
        end
      end
    end
    // An unlocked match is always younger than a locked head.
    fwd_idx = unl_hit ? unl_idx : head;
  end

  assign push = wr_acc && !unl_hit;
  assign pop  = (state == WR_ISSUE) && mem_ready;

  // Next-state selection for the memory-port FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_hit_acc)          state_nxt = RD_FWD;
        else if (rd_miss_acc)    state_nxt = RD_ISSUE;
        else if (count != '0)    state_nxt = WR_ISSUE;
      end
      RD_FWD:   state_nxt = IDLE;
      RD_ISSUE: if (mem_ready)  state_nxt = RD_WAIT;
      RD_WAIT:  if (mem_rvalid) state_nxt = IDLE;
      WR_ISSUE: begin
        if (mem_ready) state_nxt = (rd_pend || rd_miss_acc) ? RD_ISSUE : IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM, pointers, occupancy and read bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      wb_vld  <= '0;
      rd_pend <= 1'b0;
      fwd_vld <= 1'b0;
      rd_addr <= '0;
    end else begin
      state   <= state_nxt;
      fwd_vld <= rd_hit_acc;
      rd_pend <= locked && !mem_ready && (rd_pend || rd_miss_acc);
      if (rd_miss_acc) rd_addr <= up_addr;
      if (push) begin
        wb_vld[tail] <= 1'b1;
        tail         <= tail + 1'b1;
      end
      if (pop) begin
        wb_vld[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Buffer storage and forwarded data capture; contents are qualified by wb_vld / fwd_vld.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= up_addr;
      wb_data[tail] <= up_wdata;
    end else if (wr_acc) begin
      wb_data[unl_idx] <= up_wdata;
    end
    if (rd_hit_acc) fwd_dat <= wb_data[fwd_idx];
  end

  assign mem_req   = (state == RD_ISSUE) || (state == WR_ISSUE);
  assign mem_write = (state == WR_ISSUE);
  assign mem_addr  = (state == WR_ISSUE) ? wb_addr[head] :
                     (state == RD_ISSUE) ? rd_addr : '0;
  assign mem_wdata = (state == WR_ISSUE) ? wb_data[head] : '0;

  assign up_rvalid = ((state == RD_WAIT) && mem_rvalid) || fwd_vld;
  assign up_rdata  = ((state == RD_WAIT) && mem_rvalid) ? mem_rdata :
                     fwd_vld ? fwd_dat : '0;

  assign idle     = (state == IDLE) && (count == '0);
  assign wb_count = count;

endmodule
